// File: rtl/fcmp_result_stage.sv
// Result/writeback stage behind the single-precision FP comparator.
// Forms the FEQ/FLT/FLE/FMIN/FMAX result and buffers it in a 2-entry FIFO.
module fcmp_result_stage #(
    parameter int unsigned TAG_W = 7,
    parameter int unsigned XLEN  = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_eq,
    input  logic             in_lt,
    input  logic [4:0]       in_fflags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    logic [XLEN-1:0]  data_q   [2];
    logic [4:0]       fflags_q [2];
    logic [TAG_W-1:0] tag_q    [2];
    logic [1:0]       count_q;
    logic             rd_ptr_q;
    logic             wr_ptr_q;

    logic             push;
    logic             pop;
    logic             a_nan;
    logic             b_nan;
    logic [31:0]      sel_val;
    logic [XLEN-1:0]  res_data;
    logic [4:0]       res_fflags;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_data   = out_valid ? data_q[rd_ptr_q]   : '0;
    assign out_fflags = out_valid ? fflags_q[rd_ptr_q] : '0;
    assign out_tag    = out_valid ? tag_q[rd_ptr_q]    : '0;

    // Signed-zero ordering comes from the eq & sign(a) term: min(-0,+0)=-0, max(-0,+0)=+0.
    always_comb begin
        a_nan      = (&in_a[30:23]) & (|in_a[22:0]);
        b_nan      = (&in_b[30:23]) & (|in_b[22:0]);
        sel_val    = '0;
        res_data   = '0;
        res_fflags = '0;
        case (in_op)
            OP_FEQ: begin
                res_data   = {{(XLEN-1){1'b0}}, in_eq};
                res_fflags = in_fflags;
            end
            OP_FLT: begin
                res_data   = {{(XLEN-1){1'b0}}, in_lt};
                res_fflags = in_fflags;
            end
            OP_FLE: begin
                res_data   = {{(XLEN-1){1'b0}}, in_lt | in_eq};
                res_fflags = in_fflags;
            end
            OP_FMIN, OP_FMAX: begin
                if (a_nan && b_nan)
                    sel_val = 32'h7FC0_0000;
                else if (a_nan)
                    sel_val = in_b;
                else if (b_nan)
                    sel_val = in_a;
                else if (in_op == OP_FMIN)
                    sel_val = (in_lt | (in_eq & in_a[31])) ? in_a : in_b;
                else
                    sel_val = (~in_lt & ~(in_eq & in_a[31])) ? in_a : in_b;
                res_data   = {{(XLEN-32){1'b1}}, sel_val};
                res_fflags = in_fflags;
            end
            default: begin
                res_data   = '0;
                res_fflags = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i]   <= '0;
                fflags_q[i] <= '0;
                tag_q[i]    <= '0;
            end
        end else if (flush) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q]   <= res_data;
                fflags_q[wr_ptr_q] <= res_fflags;
                tag_q[wr_ptr_q]    <= in_tag;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fcmp_result_stage.sv
// Directed bench for fcmp_result_stage: result formation, FIFO flow control, flush and async reset.
module tb_fcmp_result_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_eq;
    logic        in_lt;
    logic [4:0]  in_fflags;
    logic [6:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_fflags;
    logic [6:0]  out_tag;

    int errors = 0;
    int checks = 0;

    fcmp_result_stage #(.TAG_W(7), .XLEN(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_eq      (in_eq),
        .in_lt      (in_lt),
        .in_fflags  (in_fflags),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_fflags (out_fflags),
        .out_tag    (out_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic eq, input logic lt, input logic [4:0] ff, input logic [6:0] tag);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_eq     = eq;
        in_lt     = lt;
        in_fflags = ff;
        in_tag    = tag;
    endtask

    task automatic head(input string name, input logic [63:0] data, input logic [4:0] ff, input logic [6:0] tag);
        chk({name, "_valid"},  {63'd0, out_valid}, 64'd1);
        chk({name, "_data"},   out_data, data);
        chk({name, "_fflags"}, {59'd0, out_fflags}, {59'd0, ff});
        chk({name, "_tag"},    {57'd0, out_tag}, {57'd0, tag});
    endtask

    // Push one op with out_ready=1 and check it is at the head one edge later.
    task automatic op_check(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic eq, input logic lt, input logic [4:0] ff,
                            input logic [6:0] tag, input logic [63:0] exp_data, input logic [4:0] exp_ff);
        drive(op, a, b, eq, lt, ff, tag);
        step();
        head(name, exp_data, exp_ff, tag);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_eq = 1'b0; in_lt = 1'b0; in_fflags = '0; in_tag = '0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_fflags", {59'd0, out_fflags}, 64'd0);
        chk("rst_out_tag",   {57'd0, out_tag}, 64'd0);
        step();
        reset = 1'b1;
        step();

        // Compare ops, back-to-back with simultaneous push/pop at count 1
        op_check("flt",  3'd1, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 5'h00, 7'd5,
                 64'h1, 5'h00);
        op_check("feq0", 3'd0, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 5'h00, 7'd6,
                 64'h0, 5'h00);
        op_check("fle",  3'd2, 32'h40000000, 32'h40000000, 1'b1, 1'b0, 5'h00, 7'd7,
                 64'h1, 5'h00);
        op_check("flt_nan", 3'd1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 5'h10, 7'd8,
                 64'h0, 5'h10);
        op_check("fmin_anan", 3'd3, 32'h7FC00000, 32'hBF800000, 1'b0, 1'b0, 5'h00, 7'd9,
                 64'hFFFFFFFF_BF800000, 5'h00);
        op_check("fmax_bothnan", 3'd4, 32'h7F800001, 32'h7F800001, 1'b0, 1'b0, 5'h10, 7'd10,
                 64'hFFFFFFFF_7FC00000, 5'h10);
        op_check("fmax_bnan", 3'd4, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 5'h00, 7'd11,
                 64'hFFFFFFFF_3F800000, 5'h00);
        op_check("fmin_zero", 3'd3, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 5'h00, 7'd12,
                 64'hFFFFFFFF_80000000, 5'h00);
        op_check("fmax_zero", 3'd4, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 5'h00, 7'd13,
                 64'hFFFFFFFF_00000000, 5'h00);
        op_check("fmin_zero_sw", 3'd3, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 5'h00, 7'd14,
                 64'hFFFFFFFF_80000000, 5'h00);
        op_check("fmax_zero_sw", 3'd4, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 5'h00, 7'd15,
                 64'hFFFFFFFF_00000000, 5'h00);
        op_check("fmin_num", 3'd3, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 5'h00, 7'd16,
                 64'hFFFFFFFF_3F800000, 5'h00);
        op_check("fmax_num", 3'd4, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 5'h00, 7'd17,
                 64'hFFFFFFFF_40000000, 5'h00);
        op_check("reserved", 3'd6, 32'h3F800000, 32'h40000000, 1'b1, 1'b1, 5'h1F, 7'd18,
                 64'h0, 5'h00);
        in_valid = 1'b0;
        step();
        chk("drain_empty", {63'd0, out_valid}, 64'd0);
        chk("drain_data",  out_data, 64'd0);

        // Backpressure: fill to 2, third op held off, drain in order
        out_ready = 1'b0;
        drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 5'h00, 7'd1);
        step();
        chk("bp_ready1", {63'd0, in_ready}, 64'd1);
        head("bp_h1", 64'h1, 5'h00, 7'd1);
        drive(3'd1, 32'h0, 32'h0, 1'b0, 1'b1, 5'h00, 7'd2);
        step();
        chk("bp_ready2", {63'd0, in_ready}, 64'd0);
        drive(3'd2, 32'h0, 32'h0, 1'b0, 1'b0, 5'h01, 7'd3);
        step();
        chk("bp_held_ready", {63'd0, in_ready}, 64'd0);
        head("bp_held", 64'h1, 5'h00, 7'd1);
        out_ready = 1'b1;
        step();
        chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        head("bp_h2", 64'h1, 5'h00, 7'd2);
        step();
        head("bp_h3", 64'h0, 5'h01, 7'd3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush at count 2 with a concurrent push
        out_ready = 1'b0;
        drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 5'h00, 7'd20);
        step();
        drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 5'h00, 7'd21);
        step();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 5'h00, 7'd22);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("fl_out_tag",   {57'd0, out_tag}, 64'd0);
        step();
        chk("fl_never_appears", {63'd0, out_valid}, 64'd0);
        op_check("fl_after", 3'd1, 32'h0, 32'h0, 1'b0, 1'b1, 5'h00, 7'd23, 64'h1, 5'h00);
        in_valid = 1'b0;
        step();

        // Async reset mid-stream with one entry buffered
        out_ready = 1'b0;
        drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 5'h04, 7'd30);
        step();
        in_valid = 1'b0;
        head("ar_before", 64'h1, 5'h04, 7'd30);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("ar_out_data",  out_data, 64'd0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        op_check("ar_after", 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, 5'h00, 7'd31, 64'h1, 5'h00);
        in_valid = 1'b0;
        step();
        chk("ar_final_empty", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
